// File: rtl/ahb_refill_ctrl_if.sv
// AHB-Lite read-only master bundle used by the refill sequencer.
interface ahb_refill_ctrl_if;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hburst;
  logic [2:0]  hsize;
  logic        hwrite;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  modport master (output haddr, htrans, hburst, hsize, hwrite,
                  input  hrdata, hready, hresp);
  modport slave  (input  haddr, htrans, hburst, hsize, hwrite,
                  output hrdata, hready, hresp);
endinterface

// File: rtl/ahb_refill_ctrl.sv
// I-cache line refill sequencer: one miss at a time, fetched as a pipelined
// AHB read burst; words are returned with their index inside the line.
module ahb_refill_ctrl #(
  parameter int LINE_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          miss_req,
  input  logic [31:0]                   miss_addr,
  output logic                          miss_ack,
  output logic                          fill_valid,
  output logic [$clog2(LINE_WORDS)-1:0] fill_idx,
  output logic [31:0]                   fill_data,
  output logic                          fill_done,
  output logic                          bus_err,
  ahb_refill_ctrl_if.master             ahb
);
  localparam int IW  = $clog2(LINE_WORDS);
  localparam int CW  = IW + 1;
  localparam int OFS = IW + 2;
  localparam logic [CW-1:0] NW   = CW'(LINE_WORDS);
  localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);
  localparam logic [1:0] T_IDLE = 2'b00, T_NONSEQ = 2'b10, T_SEQ = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_ERR} state_t;

  state_t        state_q, state_d;
  logic [31:0]   base_q, haddr_q, haddr_c;
  logic [CW-1:0] addr_cnt, data_cnt;
  logic          data_pend;
  logic [1:0]    htrans_c;
  logic          addr_acc, data_cap;

  assign ahb.haddr  = haddr_c;
  assign ahb.htrans = htrans_c;
  assign ahb.hburst = (LINE_WORDS == 4) ? 3'b011 : 3'b001;
  assign ahb.hsize  = 3'b010;
  assign ahb.hwrite = 1'b0;

  // Address beat taken when the bus is ready and we are driving a transfer;
  // data beat captured only on an OKAY completion while in the burst.
  assign addr_acc = ahb.hready && (htrans_c != T_IDLE);
  assign data_cap = (state_q == S_XFER) && data_pend && ahb.hready && !ahb.hresp;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state plus address-phase drive; haddr parks on its last value when idle
  always_comb begin
    state_d  = state_q;
    htrans_c = T_IDLE;
    haddr_c  = haddr_q;
    case (state_q)
      S_IDLE: if (miss_req) state_d = S_XFER;
      S_XFER: begin
        if (addr_cnt < NW) begin
          htrans_c = (addr_cnt == '0) ? T_NONSEQ : T_SEQ;
          haddr_c  = base_q + {{(30-CW){1'b0}}, addr_cnt, 2'b00};
        end
        if (data_pend && ahb.hready && !ahb.hresp && data_cnt == LAST)
          state_d = S_IDLE;
        else if (data_pend && !ahb.hready && ahb.hresp)
          state_d = S_ERR;
      end
      S_ERR: if (ahb.hready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request latch, beat counters, data capture and status pulses
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      base_q     <= '0;
      haddr_q    <= '0;
      addr_cnt   <= '0;
      data_cnt   <= '0;
      data_pend  <= 1'b0;
      miss_ack   <= 1'b0;
      fill_valid <= 1'b0;
      fill_idx   <= '0;
      fill_data  <= '0;
      fill_done  <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      miss_ack   <= 1'b0;
      fill_valid <= 1'b0;
      fill_done  <= 1'b0;
      bus_err    <= 1'b0;
      haddr_q    <= haddr_c;
      if (state_q == S_IDLE && miss_req) begin
        base_q   <= {miss_addr[31:OFS], {OFS{1'b0}}};
        addr_cnt <= '0;
        data_cnt <= '0;
        miss_ack <= 1'b1;
      end
      // Wait states freeze the pipeline flag; a ready idle cycle clears it
      if (ahb.hready) data_pend <= addr_acc;
      if (addr_acc) addr_cnt <= addr_cnt + 1'b1;
      if (data_cap) begin
        fill_data  <= ahb.hrdata;
        fill_idx   <= data_cnt[IW-1:0];
        fill_valid <= 1'b1;
        fill_done  <= (data_cnt == LAST);
        data_cnt   <= data_cnt + 1'b1;
      end
      if (state_q == S_ERR && ahb.hready) bus_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ahb_refill_ctrl.sv
// Bench for ahb_refill_ctrl: a memory-backed AHB slave with scripted or
// random wait states, and expected lines built from the miss address alone.
module tb_ahb_refill_ctrl;
  localparam int LW = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        miss_req;
  logic [31:0] miss_addr;
  logic        miss_ack, fill_valid, fill_done, bus_err;
  logic [1:0]  fill_idx;
  logic [31:0] fill_data;

  ahb_refill_ctrl_if bus();

  ahb_refill_ctrl #(.LINE_WORDS(LW)) dut (
    .clk(clk), .rstn(rstn), .miss_req(miss_req), .miss_addr(miss_addr),
    .miss_ack(miss_ack), .fill_valid(fill_valid), .fill_idx(fill_idx),
    .fill_data(fill_data), .fill_done(fill_done), .bus_err(bus_err),
    .ahb(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc = 0;
  int rdy_mode = 0, stall_cnt = 0, err_step = 0, n_berr = 0;
  bit err_armed = 0;
  logic [31:0] err_addr;
  logic [31:0] aq_addr[$];
  logic [1:0]  aq_trans[$];
  int          fq_idx[$];
  logic [31:0] fq_data[$];
  bit          fq_done[$];
  int          ack_cyc[$];
  int          done_cyc[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] base_of(input logic [31:0] a);
    return a & ~32'(LW*4-1);
  endfunction

  // Slave data phase: remember which address is currently being answered
  logic        dp_valid;
  logic [31:0] dp_addr;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dp_valid <= 1'b0;
      dp_addr  <= '0;
    end else if (bus.hready) begin
      dp_valid <= bus.htrans[1];
      dp_addr  <= bus.haddr;
    end
  end
  assign bus.hrdata = dp_valid ? mem_word(dp_addr) : 32'h0;

  task automatic clear_q();
    aq_addr.delete(); aq_trans.delete(); fq_idx.delete(); fq_data.delete();
    fq_done.delete(); ack_cyc.delete(); done_cyc.delete(); n_berr = 0;
  endtask

  // Advance one clock, drive slave response for the next edge, log events
  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    bus.hresp = 1'b0;
    case (rdy_mode)
      1: bus.hready = ($urandom_range(0, 3) != 0);
      2: if (dp_valid && stall_cnt < 2) begin bus.hready = 1'b0; stall_cnt++; end
         else begin bus.hready = 1'b1; stall_cnt = 0; end
      default: bus.hready = 1'b1;
    endcase
    if (err_step == 1) begin
      bus.hresp = 1'b1; bus.hready = 1'b1; err_step = 2;
    end else if (err_armed && err_step == 0 && dp_valid && dp_addr == err_addr) begin
      bus.hresp = 1'b1; bus.hready = 1'b0; err_step = 1;
    end
    if (fill_valid) begin
      fq_idx.push_back(int'(fill_idx)); fq_data.push_back(fill_data); fq_done.push_back(fill_done);
    end
    if (fill_done) done_cyc.push_back(cyc);
    if (bus_err) n_berr++;
    if (miss_ack) ack_cyc.push_back(cyc);
    if (bus.hready && bus.htrans != 2'b00) begin
      aq_addr.push_back(bus.haddr); aq_trans.push_back(bus.htrans);
    end
  endtask

  // Issue one miss and run until the line completes or aborts
  task automatic do_line(input logic [31:0] a, output int c0, output bit to);
    clear_q();
    miss_addr = a; miss_req = 1'b1; c0 = cyc; to = 1'b0;
    for (int k = 0; k < 100 && ack_cyc.size() == 0; k++) tick();
    miss_req = 1'b0;
    for (int k = 0; k < 300 && done_cyc.size() == 0 && n_berr == 0; k++) tick();
    if (ack_cyc.size() == 0 || (done_cyc.size() == 0 && n_berr == 0)) to = 1'b1;
    for (int k = 0; k < 3; k++) tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0; miss_req = 1'b0; miss_addr = '0; bus.hready = 1'b1; bus.hresp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (miss_ack !== 1'b0) begin n_fail++; $display("FAIL reset_miss_ack got=%b exp=0", miss_ack); end
    n_chk++; if (fill_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fill_valid got=%b exp=0", fill_valid); end
    n_chk++; if (fill_idx !== 2'd0) begin n_fail++; $display("FAIL reset_fill_idx got=%0d exp=0", fill_idx); end
    n_chk++; if (fill_data !== 32'h0) begin n_fail++; $display("FAIL reset_fill_data got=%h exp=0", fill_data); end
    n_chk++; if (fill_done !== 1'b0) begin n_fail++; $display("FAIL reset_fill_done got=%b exp=0", fill_done); end
    n_chk++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_bus_err got=%b exp=0", bus_err); end
    n_chk++; if (bus.htrans !== 2'b00) begin n_fail++; $display("FAIL reset_htrans got=%b exp=00", bus.htrans); end
    n_chk++; if (bus.haddr !== 32'h0) begin n_fail++; $display("FAIL reset_haddr got=%h exp=0", bus.haddr); end
    n_chk++; if (bus.hburst !== 3'b011) begin n_fail++; $display("FAIL hburst got=%b exp=011", bus.hburst); end
    n_chk++; if (bus.hsize !== 3'b010) begin n_fail++; $display("FAIL hsize got=%b exp=010", bus.hsize); end
    n_chk++; if (bus.hwrite !== 1'b0) begin n_fail++; $display("FAIL hwrite got=%b exp=0", bus.hwrite); end
    rstn = 1'b1;
    tick(); tick();
  endtask

  task automatic test_zero_wait();
    int c0; bit to; logic [31:0] b;
    rdy_mode = 0;
    do_line(32'h1000_0014, c0, to);
    b = base_of(32'h1000_0014);
    n_chk++; if (to) begin n_fail++; $display("FAIL zw_timeout got=timeout exp=done"); end
    n_chk++; if (ack_cyc.size() != 1 || ack_cyc[0] - c0 != 1) begin n_fail++; $display("FAIL zw_ack_latency got=%0d exp=1", ack_cyc.size() ? ack_cyc[0] - c0 : -1); end
    n_chk++; if (done_cyc.size() != 1 || done_cyc[0] - c0 != 6) begin n_fail++; $display("FAIL zw_done_latency got=%0d exp=6", done_cyc.size() ? done_cyc[0] - c0 : -1); end
    n_chk++; if (aq_addr.size() != LW) begin n_fail++; $display("FAIL zw_addr_count got=%0d exp=%0d", aq_addr.size(), LW); end
    for (int i = 0; i < LW && i < aq_addr.size(); i++) begin
      n_chk++;
      if (aq_addr[i] !== b + 32'(4*i) || aq_trans[i] !== (i == 0 ? 2'b10 : 2'b11)) begin
        n_fail++; $display("FAIL zw_addr[%0d] got=%h/%b exp=%h/%b", i, aq_addr[i], aq_trans[i], b + 32'(4*i), (i == 0 ? 2'b10 : 2'b11));
      end
    end
    n_chk++; if (fq_idx.size() != LW) begin n_fail++; $display("FAIL zw_fill_count got=%0d exp=%0d", fq_idx.size(), LW); end
    for (int i = 0; i < LW && i < fq_idx.size(); i++) begin
      n_chk++;
      if (fq_idx[i] != i || fq_data[i] !== mem_word(b + 32'(4*i)) || fq_done[i] != (i == LW-1)) begin
        n_fail++; $display("FAIL zw_fill[%0d] got=%0d/%h/%b exp=%0d/%h/%b", i, fq_idx[i], fq_data[i], fq_done[i], i, mem_word(b + 32'(4*i)), i == LW-1);
      end
    end
    n_chk++; if (bus.htrans !== 2'b00 || bus.haddr !== b + 32'hC) begin n_fail++; $display("FAIL zw_idle_hold got=%b/%h exp=00/%h", bus.htrans, bus.haddr, b + 32'hC); end
  endtask

  task automatic test_wait_states();
    logic [31:0] b, p_addr; logic [1:0] p_trans; logic p_rdy; int n_hold;
    clear_q(); rdy_mode = 2; stall_cnt = 0; n_hold = 0; p_rdy = 1'b1; p_addr = '0; p_trans = '0;
    miss_addr = 32'h2000_0128; miss_req = 1'b1; b = base_of(miss_addr);
    for (int k = 0; k < 200 && done_cyc.size() == 0; k++) begin
      tick();
      if (ack_cyc.size() > 0) miss_req = 1'b0;
      if (!p_rdy) begin
        n_hold++; n_chk++;
        if (bus.haddr !== p_addr || bus.htrans !== p_trans) begin
          n_fail++; $display("FAIL ws_hold got=%h/%b exp=%h/%b", bus.haddr, bus.htrans, p_addr, p_trans);
        end
      end
      p_rdy = bus.hready; p_addr = bus.haddr; p_trans = bus.htrans;
    end
    miss_req = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    rdy_mode = 0;
    n_chk++; if (n_hold < 2*LW) begin n_fail++; $display("FAIL ws_stalls got=%0d exp>=%0d", n_hold, 2*LW); end
    n_chk++; if (done_cyc.size() != 1) begin n_fail++; $display("FAIL ws_done_count got=%0d exp=1", done_cyc.size()); end
    n_chk++; if (fq_idx.size() != LW) begin n_fail++; $display("FAIL ws_fill_count got=%0d exp=%0d", fq_idx.size(), LW); end
    for (int i = 0; i < LW && i < fq_idx.size(); i++) begin
      n_chk++;
      if (fq_idx[i] != i || fq_data[i] !== mem_word(b + 32'(4*i)) || fq_done[i] != (i == LW-1)) begin
        n_fail++; $display("FAIL ws_fill[%0d] got=%0d/%h/%b exp=%0d/%h/%b", i, fq_idx[i], fq_data[i], fq_done[i], i, mem_word(b + 32'(4*i)), i == LW-1);
      end
    end
  endtask

  task automatic test_error();
    logic [31:0] b; bit seen1, seen2;
    clear_q(); rdy_mode = 0; seen1 = 0; seen2 = 0;
    miss_addr = 32'h3000_0040; b = base_of(miss_addr);
    err_addr = b + 32'h8; err_step = 0; err_armed = 1; miss_req = 1'b1;
    for (int k = 0; k < 100 && n_berr == 0; k++) begin
      tick();
      if (ack_cyc.size() > 0) miss_req = 1'b0;
      if (err_step == 1 && !seen1) begin
        seen1 = 1; n_chk++;
        if (bus.htrans !== 2'b11 || bus.haddr !== b + 32'hC) begin n_fail++; $display("FAIL err_cycle1 got=%b/%h exp=11/%h", bus.htrans, bus.haddr, b + 32'hC); end
      end
      if (err_step == 2 && !seen2) begin
        seen2 = 1; n_chk++;
        if (bus.htrans !== 2'b00) begin n_fail++; $display("FAIL err_cycle2_htrans got=%b exp=00", bus.htrans); end
      end
    end
    miss_req = 1'b0; err_armed = 0;
    for (int k = 0; k < 6; k++) tick();
    err_step = 0;
    n_chk++; if (!seen2) begin n_fail++; $display("FAIL err_reached got=0 exp=1"); end
    n_chk++; if (n_berr != 1) begin n_fail++; $display("FAIL err_bus_err_pulses got=%0d exp=1", n_berr); end
    n_chk++; if (done_cyc.size() != 0) begin n_fail++; $display("FAIL err_fill_done got=%0d exp=0", done_cyc.size()); end
    n_chk++; if (fq_idx.size() != 2) begin n_fail++; $display("FAIL err_fill_count got=%0d exp=2", fq_idx.size()); end
    for (int i = 0; i < 2 && i < fq_idx.size(); i++) begin
      n_chk++;
      if (fq_idx[i] != i || fq_data[i] !== mem_word(b + 32'(4*i))) begin
        n_fail++; $display("FAIL err_fill[%0d] got=%0d/%h exp=%0d/%h", i, fq_idx[i], fq_data[i], i, mem_word(b + 32'(4*i)));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] bb;
    clear_q(); rdy_mode = 0;
    miss_addr = 32'h4000_0000; miss_req = 1'b1;
    for (int k = 0; k < 50 && ack_cyc.size() < 1; k++) tick();
    miss_addr = 32'h4000_0A5C; bb = base_of(miss_addr);
    for (int k = 0; k < 50 && ack_cyc.size() < 2; k++) tick();
    miss_req = 1'b0;
    for (int k = 0; k < 50 && done_cyc.size() < 2; k++) tick();
    for (int k = 0; k < 3; k++) tick();
    n_chk++; if (ack_cyc.size() != 2 || done_cyc.size() != 2) begin n_fail++; $display("FAIL b2b_counts got=%0d/%0d exp=2/2", ack_cyc.size(), done_cyc.size()); end
    else begin
      n_chk++; if (ack_cyc[1] != done_cyc[0] + 1) begin n_fail++; $display("FAIL b2b_ack_gap got=%0d exp=1", ack_cyc[1] - done_cyc[0]); end
    end
    n_chk++;
    if (aq_addr.size() != 2*LW) begin n_fail++; $display("FAIL b2b_addr_count got=%0d exp=%0d", aq_addr.size(), 2*LW); end
    else if (aq_addr[LW] !== bb || aq_trans[LW] !== 2'b10) begin n_fail++; $display("FAIL b2b_second_nonseq got=%h/%b exp=%h/10", aq_addr[LW], aq_trans[LW], bb); end
    n_chk++; if (fq_idx.size() != 2*LW) begin n_fail++; $display("FAIL b2b_fill_count got=%0d exp=%0d", fq_idx.size(), 2*LW); end
    for (int i = 0; i < LW && LW + i < fq_idx.size(); i++) begin
      n_chk++;
      if (fq_idx[LW+i] != i || fq_data[LW+i] !== mem_word(bb + 32'(4*i))) begin
        n_fail++; $display("FAIL b2b_fill[%0d] got=%0d/%h exp=%0d/%h", i, fq_idx[LW+i], fq_data[LW+i], i, mem_word(bb + 32'(4*i)));
      end
    end
  endtask

  task automatic test_random();
    int c0; bit to; logic [31:0] a, b; int bad;
    rdy_mode = 1;
    for (int n = 0; n < 8; n++) begin
      a = (n == 0) ? 32'hFFFF_FFFC : $urandom;
      b = base_of(a);
      do_line(a, c0, to);
      bad = 0;
      if (to || done_cyc.size() != 1 || aq_addr.size() != LW || fq_idx.size() != LW) bad = 1;
      for (int i = 0; i < LW && !bad; i++) begin
        if (aq_addr[i] !== b + 32'(4*i) || aq_trans[i] !== (i == 0 ? 2'b10 : 2'b11)) bad = 1;
        if (fq_idx[i] != i || fq_data[i] !== mem_word(b + 32'(4*i)) || fq_done[i] != (i == LW-1)) bad = 1;
      end
      n_chk++;
      if (bad) begin n_fail++; $display("FAIL rand_line[%0d] addr=%h got fills=%0d beats=%0d dones=%0d exp %0d/%0d/1 in order", n, a, fq_idx.size(), aq_addr.size(), done_cyc.size(), LW, LW); end
    end
    rdy_mode = 0;
  endtask

  task automatic test_reset_mid();
    int c0; bit to; logic [31:0] b;
    clear_q(); rdy_mode = 0;
    miss_addr = 32'h5000_0070; miss_req = 1'b1;
    for (int k = 0; k < 50 && fq_idx.size() < 1; k++) begin
      tick();
      if (ack_cyc.size() > 0) miss_req = 1'b0;
    end
    miss_req = 1'b0;
    rstn = 1'b0; #1;
    n_chk++;
    if (miss_ack !== 0 || fill_valid !== 0 || fill_idx !== 0 || fill_data !== 0 || fill_done !== 0 ||
        bus_err !== 0 || bus.htrans !== 2'b00 || bus.haddr !== 32'h0) begin
      n_fail++; $display("FAIL rst_mid_outputs got=%b%b%0d/%h%b%b/%b/%h exp=all zero", miss_ack, fill_valid, fill_idx, fill_data, fill_done, bus_err, bus.htrans, bus.haddr);
    end
    tick();
    rstn = 1'b1;
    tick();
    do_line(32'h6000_0304, c0, to);
    b = base_of(32'h6000_0304);
    n_chk++; if (to || aq_addr.size() == 0 || aq_addr[0] !== b || aq_trans[0] !== 2'b10) begin n_fail++; $display("FAIL rst_mid_restart got=%0d beats exp=NONSEQ at %h", aq_addr.size(), b); end
    n_chk++; if (fq_idx.size() != LW || fq_idx[0] != 0 || done_cyc.size() != 1) begin n_fail++; $display("FAIL rst_mid_refill got=%0d fills exp=%0d from idx 0", fq_idx.size(), LW); end
    for (int i = 0; i < LW && i < fq_idx.size(); i++) begin
      n_chk++;
      if (fq_idx[i] != i || fq_data[i] !== mem_word(b + 32'(4*i))) begin
        n_fail++; $display("FAIL rst_mid_fill[%0d] got=%0d/%h exp=%0d/%h", i, fq_idx[i], fq_data[i], i, mem_word(b + 32'(4*i)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_error();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
